// File: rtl/cdc_gray_sync.sv
// Gray-coded bus synchroniser with change pulse and non-gray transition detection (error pulse, sticky flag, saturating counter).
// Define CDC_GRAY_SYNC_BIN_OUT_EN to add the registered gray-to-binary output bin_o.
module cdc_gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_clr_i,
  output logic [WIDTH-1:0] data_sync_o,
  output logic             chg_o,
  output logic             err_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] err_cnt_o
`ifdef CDC_GRAY_SYNC_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] bin_o
`endif
);

  localparam int AW = $clog2(STAGES + 1) + 1;

  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             hist;
  logic [WIDTH-1:0]             diff;
  logic [AW-1:0]                arm_cnt;
  logic                         armed;
  logic                         err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain <= '0;
      hist  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], data_i};
      hist  <= chain[STAGES-1];
    end
  end

  assign data_sync_o = chain[STAGES-1];
  assign diff        = data_sync_o ^ hist;
  assign chg_o       = |diff;

  // Suppress errors until the chain and history hold post-reset samples only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
      if (arm_cnt == AW'(STAGES)) armed <= 1'b1;
    end
  end

  generate
    if (WIDTH > 1) begin : g_err
      // Two or more differing bits: clearing the lowest set bit leaves something.
      assign err = armed & (|(diff & (diff - 1'b1)));
    end else begin : g_no_err
      assign err = 1'b0;
    end
  endgenerate

  assign err_o = err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_sticky_o <= 1'b0;
      err_cnt_o    <= '0;
    end else if (err) begin
      err_sticky_o <= 1'b1;
      if (err_clr_i)            err_cnt_o <= CNT_W'(1);
      else if (~&err_cnt_o)     err_cnt_o <= err_cnt_o + 1'b1;
    end else if (err_clr_i) begin
      err_sticky_o <= 1'b0;
      err_cnt_o    <= '0;
    end
  end

`ifdef CDC_GRAY_SYNC_BIN_OUT_EN
  logic [WIDTH-1:0] bin_nxt;

  always_comb begin
    bin_nxt = '0;
    for (int i = 0; i < WIDTH; i++) bin_nxt[i] = ^(data_sync_o >> i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bin_o <= '0;
    else       bin_o <= bin_nxt;
  end
`endif

endmodule

// File: tb/tb_cdc_gray_sync.sv
// Directed + scoreboard bench for cdc_gray_sync (WIDTH=4, STAGES=2, CNT_W=2).
module tb_cdc_gray_sync;
  localparam int W = 4;
  localparam int ST = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_i;
  logic          err_clr_i;
  logic [W-1:0]  data_sync_o;
  logic          chg_o;
  logic          err_o;
  logic          err_sticky_o;
  logic [CW-1:0] err_cnt_o;
`ifdef CDC_GRAY_SYNC_BIN_OUT_EN
  logic [W-1:0]  bin_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  q[$];
  logic [W-1:0]  m_sync, m_h;
  logic          m_err, m_sticky;
  logic [CW-1:0] m_cnt;
  int            n;

  cdc_gray_sync #(.WIDTH(W), .STAGES(ST), .CNT_W(CW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_i       (data_i),
    .err_clr_i    (err_clr_i),
    .data_sync_o  (data_sync_o),
    .chg_o        (chg_o),
    .err_o        (err_o),
    .err_sticky_o (err_sticky_o),
    .err_cnt_o    (err_cnt_o)
`ifdef CDC_GRAY_SYNC_BIN_OUT_EN
    ,
    .bin_o        (bin_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_sync"}, data_sync_o, 0);
    chk({tag, "_chg"}, chg_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_sticky"}, err_sticky_o, 0);
    chk({tag, "_cnt"}, err_cnt_o, 0);
`ifdef CDC_GRAY_SYNC_BIN_OUT_EN
    chk({tag, "_bin"}, bin_o, 0);
`endif
  endtask

  // Push the driven word, advance one edge, pop what should now be at the output.
  task automatic tick();
    logic pend_err, pend_clr;
    logic [W-1:0] exp_bin;
    q.push_back(data_i);
    pend_err = m_err;
    pend_clr = err_clr_i;
    @(posedge clk);
    #1;
    n++;
    if (pend_err) begin
      m_sticky = 1'b1;
      if (pend_clr)           m_cnt = 1;
      else if (m_cnt != 2'd3) m_cnt = m_cnt + 1'b1;
    end else if (pend_clr) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
    end
    exp_bin = g2b(m_sync);
    m_h = m_sync;
    if (q.size() == ST) m_sync = q.pop_front();
    m_err = (n >= ST + 1) && ($countones(m_sync ^ m_h) >= 2);
    chk("sb_sync", data_sync_o, m_sync);
    chk("sb_chg", chg_o, m_sync != m_h);
    chk("sb_err", err_o, m_err);
    chk("sb_sticky", err_sticky_o, m_sticky);
    chk("sb_cnt", err_cnt_o, m_cnt);
`ifdef CDC_GRAY_SYNC_BIN_OUT_EN
    chk("sb_bin", bin_o, exp_bin);
`endif
  endtask

  task automatic do_reset(input logic [W-1:0] d_during);
    rst = 1'b1;
    #1;
    chk_zero("rst_now");
    data_i = d_during;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    rst = 1'b0;
    q.delete();
    m_sync = '0; m_h = '0; m_err = 1'b0; m_sticky = 1'b0; m_cnt = '0; n = 0;
  endtask

  initial begin
    int chg_seen, err_seen;
    logic [CW-1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; data_i = '0; err_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset('0);

    // First transaction: single-bit change, two-cycle latency, no error.
    repeat (4) tick();
    data_i = 4'b0001;
    tick();
    chk("lat_early", data_sync_o, 4'b0000);
    tick();
    chk("lat_sync", data_sync_o, 4'b0001);
    chk("lat_chg", chg_o, 1);
    chk("lat_err", err_o, 0);
    tick();
    chk("lat_chg_off", chg_o, 0);

    // Two-bit transition once armed.
    data_i = 4'b0010;
    tick(); tick();
    chk("err_pulse", err_o, 1);
    tick();
    chk("err_one_cycle", err_o, 0);
    chk("err_sticky", err_sticky_o, 1);
    chk("err_cnt1", err_cnt_o, 1);

    // Clear without concurrent error.
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("clr_sticky", err_sticky_o, 0);
    chk("clr_cnt", err_cnt_o, 0);

    // Five back-to-back two-bit transitions saturate the 2-bit counter.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) data_i = (i % 2 == 0) ? 4'b0001 : 4'b0010;
      tick();
      if (i >= 2) begin
        chk("sat_cnt", err_cnt_o, exp_seq[i-2]);
        chk("sat_sticky", err_sticky_o, 1);
      end
    end

    // Clear coincident with an error while count is 2: the error survives.
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    data_i = 4'b0010; tick();
    data_i = 4'b0001; tick();
    data_i = 4'b0010; tick();
    tick();
    chk("clrerr_pre_err", err_o, 1);
    chk("clrerr_pre_cnt", err_cnt_o, 2);
    err_clr_i = 1'b1; tick(); err_clr_i = 1'b0;
    chk("clrerr_cnt", err_cnt_o, 1);
    chk("clrerr_sticky", err_sticky_o, 1);

    // Gray walk: never an error.
    for (int i = 0; i < 8; i++) begin
      data_i = 4'(i ^ (i >> 1));
      tick();
    end

    // Random words with occasional clears.
    for (int i = 0; i < 16; i++) begin
      data_i = 4'($urandom_range(0, 15));
      err_clr_i = ($urandom_range(0, 3) == 0);
      tick();
    end
    err_clr_i = 1'b0;

    // Settle on 0110 for the binary decode, then reset with data in flight.
    data_i = 4'b0110;
    repeat (3) tick();
`ifdef CDC_GRAY_SYNC_BIN_OUT_EN
    chk("bin_0110", bin_o, 4'b0100);
`endif
    data_i = 4'b1010;
    tick();
    do_reset(4'b0011);

    // Word held through reset release: one change pulse, no error, no count.
    chg_seen = 0; err_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chg_seen += int'(chg_o);
      err_seen += int'(err_o);
    end
    chk("hold_chg_cnt", chg_seen, 1);
    chk("hold_err_cnt", err_seen, 0);
    chk("hold_cnt", err_cnt_o, 0);
    chk("hold_sync", data_sync_o, 4'b0011);

    // Re-armed after reset: a two-bit step is flagged again.
    data_i = 4'b0000;
    tick(); tick();
    chk("rearm_err", err_o, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
